// File: rtl/cmos_frame_crop_if.sv
// Camera-side pixel stream in, cropped display stream and frame status out.
interface cmos_frame_crop_if;
  logic        vs_i;
  logic        de_i;
  logic [15:0] pdata_i;
  logic        de_o;
  logic [15:0] pdata_o;
  logic        frame_start;
  logic        frame_err;
  logic [7:0]  frame_cnt;
  logic [11:0] line_cnt;

  // Crop block view: consumes the camera stream, produces the cropped stream.
  modport slave (
    input  vs_i, de_i, pdata_i,
    output de_o, pdata_o, frame_start, frame_err, frame_cnt, line_cnt
  );

  // Source/sink view: drives the camera stream, observes the cropped stream.
  modport master (
    output vs_i, de_i, pdata_i,
    input  de_o, pdata_o, frame_start, frame_err, frame_cnt, line_cnt
  );
endinterface

// File: rtl/cmos_frame_crop.sv
// Camera frame aligner and crop window. Locks onto vsync, counts pixels and
// lines, forwards only pixels inside the window and reports per-frame
// geometry errors plus a wrapping completed-frame count.
module cmos_frame_crop #(
  parameter int unsigned H_START  = 0,
  parameter int unsigned V_START  = 0,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned V_ACTIVE = 272,
  parameter bit          VS_POL   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  cmos_frame_crop_if.slave bus
);

  // Window bounds held one bit wider than the counters so H_START+H_ACTIVE
  // may reach 4096 without wrapping.
  localparam logic [12:0] H_LO = 13'(H_START);
  localparam logic [12:0] H_HI = 13'(H_START + H_ACTIVE);
  localparam logic [12:0] V_LO = 13'(V_START);
  localparam logic [12:0] V_HI = 13'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {SYNC, WAIT, RUN} state_t;

  state_t      state;
  logic        vs_a;
  logic        vs_d;
  logic        de_d;
  logic        boundary;
  logic        de_fall;
  logic [11:0] x_cnt;
  logic [11:0] y_cnt;
  logic        short_line;
  logic [12:0] x_ext;
  logic [12:0] y_ext;
  logic        in_h;
  logic        in_v;
  logic        pass;

  assign vs_a     = (bus.vs_i == VS_POL);
  assign boundary = vs_a & ~vs_d;
  assign de_fall  = de_d & ~bus.de_i;
  assign x_ext    = {1'b0, x_cnt};
  assign y_ext    = {1'b0, y_cnt};
  assign in_h     = (x_ext >= H_LO) && (x_ext < H_HI);
  assign in_v     = (y_ext >= V_LO) && (y_ext < V_HI);
  // The vsync cycle itself is never forwarded, even if it lands mid-line.
  assign pass     = (state == RUN) && bus.de_i && !vs_a && in_h && in_v;
  assign bus.line_cnt = y_cnt;

  // Delayed copies of vsync and pixel-valid for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      vs_d <= vs_a;
      de_d <= bus.de_i;
    end
  end

  // Frame alignment FSM with pixel/line counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= SYNC;
      x_cnt           <= '0;
      y_cnt           <= '0;
      short_line      <= 1'b0;
      bus.de_o        <= 1'b0;
      bus.pdata_o     <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.frame_cnt   <= '0;
    end else begin
      bus.frame_start <= boundary;
      bus.de_o        <= pass;
      bus.pdata_o     <= pass ? bus.pdata_i : 16'h0000;
      case (state)
        SYNC: begin
          x_cnt      <= '0;
          y_cnt      <= '0;
          short_line <= 1'b0;
          if (boundary) state <= WAIT;
        end
        WAIT: begin
          x_cnt      <= '0;
          y_cnt      <= '0;
          short_line <= 1'b0;
          if (!vs_a) state <= RUN;
        end
        RUN: begin
          if (boundary) begin
            // Frame end takes priority over a coinciding line end, so the
            // final line is judged with the line count it had before.
            state         <= WAIT;
            x_cnt         <= '0;
            bus.frame_cnt <= bus.frame_cnt + 8'd1;
            bus.frame_err <= short_line | (y_ext < V_HI);
          end else if (de_fall) begin
            x_cnt <= '0;
            if (y_cnt != 12'hFFF) y_cnt <= y_cnt + 12'd1;
            // Lines shorter than the window only matter inside the V window.
            if (in_v && (x_ext < H_HI)) short_line <= 1'b1;
          end else if (bus.de_i && (x_cnt != 12'hFFF)) begin
            x_cnt <= x_cnt + 12'd1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Directed/randomized bench for cmos_frame_crop with a frame-level model.
module tb_cmos_frame_crop;
  localparam int HS  = 2;
  localparam int HA  = 4;
  localparam int VS0 = 1;
  localparam int VA  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Frame-level reference state
  bit   running = 0;     // aligned to a frame and counting lines
  int   ycur = 0;        // completed lines in the current frame
  bit   pend_short = 0;  // a short line seen inside the V window
  int   exp_cnt = 0;
  bit   exp_err = 0;
  int   pulses = 0;
  int   exp_pulses = 0;

  cmos_frame_crop_if bus();

  cmos_frame_crop #(
    .H_START(HS), .V_START(VS0), .H_ACTIVE(HA), .V_ACTIVE(VA), .VS_POL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are checked 1 ns after the edge.
  task automatic cyc(input logic v, input logic d, input logic [15:0] p,
                     input logic e, input logic fs);
    bus.vs_i = v; bus.de_i = d; bus.pdata_i = p;
    @(posedge clk); #1;
    chk("de_o", 32'(bus.de_o), 32'(e));
    chk("pdata_o", 32'(bus.pdata_o), 32'(e ? p : 16'h0000));
    chk("frame_start", 32'(bus.frame_start), 32'(fs));
    if (bus.de_o) pulses++;
  endtask

  task automatic send_line(input int len, input bit pat, input bit gap);
    logic [15:0] data;
    logic e;
    for (int x = 0; x < len; x++) begin
      data = pat ? 16'(ycur * 16 + x) : 16'($urandom);
      e = running && x >= HS && x < HS + HA && ycur >= VS0 && ycur < VS0 + VA;
      if (e) exp_pulses++;
      cyc(1'b0, 1'b1, data, e, 1'b0);
    end
    if (gap) begin
      if (running && ycur >= VS0 && ycur < VS0 + VA && len < HS + HA) pend_short = 1;
      if (running) ycur++;
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("line_cnt", 32'(bus.line_cnt), running ? 32'(ycur) : 32'd0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic vsync(input int hi);
    if (running) begin
      exp_cnt = (exp_cnt + 1) % 256;
      exp_err = pend_short || (ycur < VS0 + VA);
    end
    running = 1; ycur = 0; pend_short = 0;
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
    chk("frame_err", 32'(bus.frame_err), 32'(exp_err));
    for (int i = 1; i < hi; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("line_cnt_clr", 32'(bus.line_cnt), 32'd0);
  endtask

  task automatic frame(input int nl, input int w, input int sy, input int sl,
                       input bit pat, input bit last_nogap);
    pulses = 0; exp_pulses = 0;
    for (int y = 0; y < nl; y++)
      send_line((y == sy) ? sl : w, pat, !(last_nogap && y == nl - 1));
    chk("pulses", 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    bus.vs_i = 1'b0; bus.de_i = 1'b0; bus.pdata_i = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de_o", 32'(bus.de_o), 32'd0);
    chk("rst_pdata_o", 32'(bus.pdata_o), 32'd0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_line_cnt", 32'(bus.line_cnt), 32'd0);
    rst = 1'b0;

    // 1: first boundary from SYNC, patterned 4x8 frame
    vsync(3);
    frame(4, 8, -1, 0, 1'b1, 1'b0);
    chk("pulses_8", 32'(pulses), 32'd8);
    // 2: second frame, counts advance
    vsync(3);
    frame(4, 8, -1, 0, 1'b0, 1'b0);
    vsync(2);
    // 3: short line inside the window, then a good frame
    frame(4, 8, 2, 5, 1'b0, 1'b0);
    vsync(2);
    frame(4, 8, -1, 0, 1'b0, 1'b0);
    vsync(2);
    // 4: too few lines, then an oversize frame
    frame(2, 8, -1, 0, 1'b0, 1'b0);
    vsync(2);
    frame(10, 20, -1, 0, 1'b0, 1'b0);
    chk("pulses_big", 32'(pulses), 32'd8);
    vsync(2);
    // last line end coincides with vsync: that line is not counted
    frame(3, 8, -1, 0, 1'b0, 1'b1);
    vsync(2);

    // 6: reset in the middle of line 1 while a pixel is being output
    frame(1, 8, -1, 0, 1'b0, 1'b0);
    for (int x = 0; x < 3; x++) cyc(1'b0, 1'b1, 16'(16'hA0 + x), x >= HS, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_de_o", 32'(bus.de_o), 32'd0);
    chk("async_pdata_o", 32'(bus.pdata_o), 32'd0);
    chk("async_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("async_frame_err", 32'(bus.frame_err), 32'd0);
    chk("async_line_cnt", 32'(bus.line_cnt), 32'd0);
    running = 0; ycur = 0; pend_short = 0; exp_cnt = 0; exp_err = 0;
    cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    #3 rst = 1'b0;
    for (int x = 4; x < 8; x++) cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    // 5: data before alignment is discarded
    pulses = 0;
    send_line(8, 1'b0, 1'b1);
    send_line(8, 1'b0, 1'b1);
    chk("pre_sync_pulses", 32'(pulses), 32'd0);
    vsync(2);
    frame(4, 8, -1, 0, 1'b0, 1'b0);
    vsync(2);
    // 5: vsync asserted during pixel 3 of line 1
    send_line(8, 1'b0, 1'b1);
    for (int x = 0; x < 3; x++) cyc(1'b0, 1'b1, 16'($urandom), x >= HS, 1'b0);
    exp_cnt = (exp_cnt + 1) % 256;
    exp_err = pend_short || (ycur < VS0 + VA);
    cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("midvs_frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
    chk("midvs_frame_err", 32'(bus.frame_err), 32'(exp_err));
    for (int x = 4; x < 8; x++) cyc(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("midvs_line_cnt", 32'(bus.line_cnt), 32'd0);
    running = 1; ycur = 0; pend_short = 0;
    frame(4, 8, -1, 0, 1'b0, 1'b0);
    vsync(2);

    // 7: 256 random frames, frame_cnt must wrap
    for (int f = 0; f < 256; f++) begin
      frame($urandom_range(1, 4), $urandom_range(3, 9), $urandom_range(0, 3),
            $urandom_range(1, 9), 1'b0, 1'b0);
      vsync($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
